// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage.
//   - default reset PC and bubble instruction (addi x0,x0,0)
//   - fetch FSM state encoding
//   - opcode field position inside a 32-bit instruction and a helper to extract it
package fetch_stage_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0013;

  // inst[6:2]; the two low bits are always 2'b11 for 32-bit encodings
  localparam int OPCODE_MSB = 6;
  localparam int OPCODE_LSB = 2;

  typedef enum logic [2:0] {
    FETCH_IDLE  = 3'd0,
    FETCH_REQ   = 3'd1,
    FETCH_WAIT  = 3'd2,
    FETCH_HOLD  = 3'd3,
    FETCH_DRAIN = 3'd4,
    FETCH_FAULT = 3'd5
  } fetch_state_e;

  function automatic logic [4:0] opcode_field(input logic [31:0] inst);
    return inst[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   flush                       empty the register (drives a bubble); beats load
//   load                        capture load_inst / load_pc / load_misaligned
//   load_inst, load_pc          incoming instruction word and its PC
//   load_misaligned             entry is an instruction-address-misaligned marker
//   valid, inst, opcode, pc,
//   pc_plus4, misaligned        registered contents presented to decode
// With neither flush nor load asserted the contents hold (decode stall).
module fetch_stage_if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        load,
  input  logic [31:0] load_inst,
  input  logic [31:0] load_pc,
  input  logic        load_misaligned,
  output logic        valid,
  output logic [31:0] inst,
  output logic [4:0]  opcode,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        misaligned
);

  logic        valid_reg;
  logic [31:0] inst_reg;
  logic [31:0] pc_reg;
  logic [31:0] pc_plus4_reg;
  logic        misaligned_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg      <= 1'b0;
      inst_reg       <= NOP_INST;
      pc_reg         <= 32'h0;
      pc_plus4_reg   <= 32'h0;
      misaligned_reg <= 1'b0;
    end else if (flush) begin
      // PC fields are left as-is; only the entry's meaning is cleared
      valid_reg      <= 1'b0;
      inst_reg       <= NOP_INST;
      misaligned_reg <= 1'b0;
    end else if (load) begin
      valid_reg      <= 1'b1;
      inst_reg       <= load_inst;
      pc_reg         <= load_pc;
      pc_plus4_reg   <= load_pc + 32'd4;
      misaligned_reg <= load_misaligned;
    end
  end

  assign valid      = valid_reg;
  assign inst       = inst_reg;
  assign opcode     = opcode_field(inst_reg);
  assign pc         = pc_reg;
  assign pc_plus4   = pc_plus4_reg;
  assign misaligned = misaligned_reg;

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch stage with IF/ID pipeline register.
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   imem_req, imem_addr               fetch request and word-aligned address
//   imem_gnt, imem_rvalid, imem_rdata memory accept / response handshake
//   redirect_valid, redirect_pc       resolved branch/jump target
//   id_stall                          decode cannot take a new instruction
//   if_id_*                           IF/ID contents presented to decode
// At most one fetch is in flight. A response that lands while IF/ID is
// blocked waits in a one-entry skid buffer. A redirect flushes IF/ID, and any
// response still owed for the old path is drained and thrown away. A
// misaligned target stops fetching and emits a single fault marker entry.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_stall,
  output logic        if_id_valid,
  output logic [31:0] if_id_inst,
  output logic [4:0]  if_id_opcode,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_misaligned
);

  fetch_state_e state_reg, state_next;
  logic [31:0]  pc_reg, pc_next;
  logic [31:0]  skid_reg, skid_next;
  logic         fault_pending_reg, fault_pending_next;

  logic        ifid_load;
  logic        ifid_flush;
  logic [31:0] ifid_inst;
  logic        ifid_misaligned;
  logic        ifid_free;
  logic        outstanding;
  logic [31:0] pc_plus4;

  // IF/ID can take a new entry if it is empty or decode consumes it this cycle
  assign ifid_free = !if_id_valid || !id_stall;
  // a granted request whose response has not yet arrived
  assign outstanding = ((state_reg == FETCH_WAIT)  && !imem_rvalid) ||
                       ((state_reg == FETCH_REQ)   && imem_gnt)     ||
                       ((state_reg == FETCH_DRAIN) && !imem_rvalid);
  assign pc_plus4  = pc_reg + 32'd4;
  assign imem_addr = {pc_reg[31:2], 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= FETCH_IDLE;
      pc_reg            <= RESET_PC;
      skid_reg          <= NOP_INST;
      fault_pending_reg <= 1'b0;
    end else begin
      state_reg         <= state_next;
      pc_reg            <= pc_next;
      skid_reg          <= skid_next;
      fault_pending_reg <= fault_pending_next;
    end
  end

  always_comb begin
    state_next         = state_reg;
    pc_next            = pc_reg;
    skid_next          = skid_reg;
    fault_pending_next = fault_pending_reg;
    imem_req           = 1'b0;
    ifid_load          = 1'b0;
    ifid_flush         = 1'b0;
    ifid_inst          = imem_rdata;
    ifid_misaligned    = 1'b0;

    case (state_reg)
      FETCH_IDLE: state_next = FETCH_REQ;
      FETCH_REQ: begin
        imem_req = 1'b1;
        if (imem_gnt) state_next = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        if (imem_rvalid) begin
          if (ifid_free) begin
            ifid_load  = 1'b1;
            pc_next    = pc_plus4;
            state_next = FETCH_REQ;
          end else begin
            skid_next  = imem_rdata;
            state_next = FETCH_HOLD;
          end
        end
      end
      FETCH_HOLD: begin
        // IF/ID is necessarily valid here, so only the stall matters
        if (!id_stall) begin
          ifid_load  = 1'b1;
          ifid_inst  = skid_reg;
          pc_next    = pc_plus4;
          state_next = FETCH_REQ;
        end
      end
      FETCH_DRAIN: begin
        if (imem_rvalid) state_next = fault_pending_reg ? FETCH_FAULT : FETCH_REQ;
      end
      FETCH_FAULT: begin
        if (fault_pending_reg && ifid_free) begin
          ifid_load          = 1'b1;
          ifid_inst          = NOP_INST;
          ifid_misaligned    = 1'b1;
          fault_pending_next = 1'b0;
        end
      end
      default: state_next = FETCH_IDLE;
    endcase

    // Redirect overrides everything decided above for this cycle
    if (redirect_valid) begin
      pc_next            = redirect_pc;
      skid_next          = NOP_INST;
      ifid_load          = 1'b0;
      fault_pending_next = |redirect_pc[1:0];
      if (outstanding)
        state_next = FETCH_DRAIN;
      else if (|redirect_pc[1:0])
        state_next = FETCH_FAULT;
      else
        state_next = FETCH_REQ;
    end

    // Consumed-but-not-refilled entries become bubbles
    ifid_flush = redirect_valid || (!id_stall && !ifid_load);
  end

  fetch_stage_if_id_reg #(
    .NOP_INST (NOP_INST)
  ) u_if_id_reg (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush           (ifid_flush),
    .load            (ifid_load),
    .load_inst       (ifid_inst),
    .load_pc         (pc_reg),
    .load_misaligned (ifid_misaligned),
    .valid           (if_id_valid),
    .inst            (if_id_inst),
    .opcode          (if_id_opcode),
    .pc              (if_id_pc),
    .pc_plus4        (if_id_pc_plus4),
    .misaligned      (if_id_misaligned)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: instruction-memory responder, scoreboard of
// expected IF/ID entries, and directed plus random stimulus.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_stall;
  logic        if_id_valid;
  logic [31:0] if_id_inst;
  logic [4:0]  if_id_opcode;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_misaligned;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_gnt         (imem_gnt),
    .imem_rvalid      (imem_rvalid),
    .imem_rdata       (imem_rdata),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .id_stall         (id_stall),
    .if_id_valid      (if_id_valid),
    .if_id_inst       (if_id_inst),
    .if_id_opcode     (if_id_opcode),
    .if_id_pc         (if_id_pc),
    .if_id_pc_plus4   (if_id_pc_plus4),
    .if_id_misaligned (if_id_misaligned)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        mis;
  } entry_t;

  entry_t sb_q[$];
  int checks_total  = 0;
  int checks_passed = 0;
  int retired       = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    if (obs !== exp) $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    else checks_passed++;
  endtask

  // memory contents: addr 0 holds addi x1,x0,5; elsewhere an address-derived pattern
  function automatic logic [31:0] inst_of(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return {a[28:2], 5'b10011};
  endfunction

  // ---------------- instruction memory responder ----------------
  logic        mem_busy = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr_q = 32'h0;
  int          mem_lat = 1;
  int          gnt_delay = 0;
  int          gnt_wait = 0;

  initial forever begin
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    imem_gnt    = 1'b0;
    if (mem_busy) begin
      if (mem_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = inst_of(mem_addr_q);
        mem_busy    = 1'b0;
      end else begin
        mem_cnt--;
      end
    end
    if (imem_req && !mem_busy && !imem_rvalid) begin
      if (gnt_wait >= gnt_delay) begin
        imem_gnt   = 1'b1;
        mem_addr_q = imem_addr;
        mem_cnt    = mem_lat - 1;
        mem_busy   = 1'b1;
        gnt_wait   = 0;
      end else begin
        gnt_wait++;
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic [31:0] exp_fetch = RST_PC;
  logic [31:0] resp_addr = 32'h0;
  logic        resp_stale = 1'b0;
  logic        hold_armed = 1'b0;
  logic [31:0] snap_inst, snap_pc, snap_pc4;
  logic [4:0]  snap_op;
  logic        snap_mis;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      sb_q.delete();
      exp_fetch  = RST_PC;
      hold_armed = 1'b0;
      if (mem_busy) resp_stale = 1'b1;
    end else begin
      if (hold_armed) begin
        check("stall_hold_valid", 32'(if_id_valid), 32'd1);
        check("stall_hold_inst", if_id_inst, snap_inst);
        check("stall_hold_opcode", 32'(if_id_opcode), 32'(snap_op));
        check("stall_hold_pc", if_id_pc, snap_pc);
        check("stall_hold_pc4", if_id_pc_plus4, snap_pc4);
        check("stall_hold_mis", 32'(if_id_misaligned), 32'(snap_mis));
      end
      hold_armed = if_id_valid && id_stall && !redirect_valid;
      snap_inst = if_id_inst; snap_op = if_id_opcode; snap_pc = if_id_pc;
      snap_pc4 = if_id_pc_plus4; snap_mis = if_id_misaligned;

      // entry consumed by decode at the coming edge
      if (if_id_valid && !id_stall && !redirect_valid) begin
        if (sb_q.size() == 0) begin
          checks_total++;
          $display("FAIL sb_unexpected: entry pc=%h inst=%h, expected no entry", if_id_pc, if_id_inst);
        end else begin
          entry_t e;
          e = sb_q.pop_front();
          retired++;
          $display("retire pc=%h inst=%h mis=%0d", if_id_pc, if_id_inst, if_id_misaligned);
          check("retire_pc", if_id_pc, e.pc);
          check("retire_inst", if_id_inst, e.inst);
          check("retire_opcode", 32'(if_id_opcode), 32'(e.inst[6:2]));
          check("retire_pc4", if_id_pc_plus4, e.pc + 32'd4);
          check("retire_mis", 32'(if_id_misaligned), 32'(e.mis));
        end
      end

      if (redirect_valid) begin
        sb_q.delete();
        if (redirect_pc[1:0] != 2'b00) begin
          entry_t f;
          f.pc = redirect_pc; f.inst = NOP; f.mis = 1'b1;
          sb_q.push_back(f);
        end
        if (mem_busy) resp_stale = 1'b1;
      end

      if (imem_rvalid) begin
        if (!resp_stale && !redirect_valid) begin
          entry_t r;
          r.pc = resp_addr; r.inst = inst_of(resp_addr); r.mis = 1'b0;
          sb_q.push_back(r);
        end
        resp_stale = 1'b0;
      end

      if (imem_req && imem_gnt) begin
        check("fetch_addr", imem_addr, exp_fetch);
        resp_addr  = exp_fetch;
        resp_stale = redirect_valid;
        exp_fetch  = exp_fetch + 32'd4;
      end
      if (redirect_valid) exp_fetch = redirect_pc;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // sel 0: IF/ID valid; 1: request outstanding with no response this cycle; 2: response this cycle
  task automatic wait_for(input int sel, input string tag);
    bit hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(posedge clk);
      #2;
      case (sel)
        0:       hit = if_id_valid;
        1:       hit = mem_busy && !imem_gnt;
        default: hit = imem_rvalid;
      endcase
    end
    if (!hit) begin
      checks_total++;
      $display("FAIL %s: condition not reached within 200 cycles", tag);
    end
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    @(posedge clk);
    #2;
    redirect_valid = 1'b0;
  endtask

  task automatic check_reset_state();
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, RST_PC);
    check("rst_valid", 32'(if_id_valid), 32'd0);
    check("rst_inst", if_id_inst, NOP);
    check("rst_opcode", 32'(if_id_opcode), 32'b00100);
    check("rst_pc", if_id_pc, 32'h0);
    check("rst_pc4", if_id_pc_plus4, 32'h0);
    check("rst_mis", 32'(if_id_misaligned), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    rst_n = 1'b0;
    id_stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    run(2);
    check_reset_state();
    rst_n = 1'b1;

    // basic fetch: first entry addi x1,x0,5 at pc 0
    wait_for(0, "first_valid");
    check("first_inst", if_id_inst, 32'h0050_0093);
    check("first_opcode", 32'(if_id_opcode), 32'b00100);
    check("first_pc", if_id_pc, 32'h0);
    check("first_pc4", if_id_pc_plus4, 32'h4);

    // decode stall for 3 cycles while the next response arrives
    id_stall = 1'b1;
    run(3);
    id_stall = 1'b0;
    run(8);

    // redirect while a response is outstanding
    mem_lat = 3;
    wait_for(1, "wait_state_for_redirect");
    do_redirect(32'h0000_0100);
    check("redirect_flush_valid", 32'(if_id_valid), 32'd0);
    check("redirect_flush_inst", if_id_inst, NOP);
    run(15);

    // redirect + stall + response in the same cycle
    mem_lat = 1;
    wait_for(2, "rvalid_for_redirect");
    id_stall = 1'b1;
    do_redirect(32'h0000_0300);
    id_stall = 1'b0;
    check("redirect_beats_stall_valid", 32'(if_id_valid), 32'd0);
    run(12);

    // misaligned target
    mem_lat = 2;
    wait_for(1, "wait_state_for_misaligned");
    do_redirect(32'h0000_0102);
    for (int i = 0; i < 12; i++) begin
      check("fault_no_req", 32'(imem_req), 32'd0);
      run(1);
    end
    check("fault_entry_emitted", 32'(sb_q.size()), 32'd0);
    do_redirect(32'h0000_0200);
    run(12);

    // PC wrap-around
    mem_lat = 1;
    do_redirect(32'hFFFF_FFF4);
    run(20);

    // reset while waiting on a response
    mem_lat = 4;
    wait_for(1, "wait_state_for_reset");
    rst_n = 1'b0;
    #1;
    check_reset_state();
    run(1);
    rst_n = 1'b1;
    run(20);

    // random stall / latency / redirect traffic
    for (int i = 0; i < 300; i++) begin
      id_stall  = ($urandom_range(0, 9) < 3);
      mem_lat   = int'($urandom_range(1, 3));
      gnt_delay = int'($urandom_range(0, 2));
      if ($urandom_range(0, 99) < 3) begin
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_1000 + 32'($urandom_range(0, 63)) * 32'd4
                      + (($urandom_range(0, 99) < 20) ? 32'd2 : 32'd0);
      end else begin
        redirect_valid = 1'b0;
      end
      run(1);
    end
    redirect_valid = 1'b0;
    id_stall = 1'b0;
    gnt_delay = 0;
    do_redirect(32'h0000_0400);
    run(20);
    check("retired_enough", 32'(retired >= 40), 32'd1);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage plus IF/ID pipeline register for the RV32I core.
- Holds the PC and issues one-outstanding word fetches to instruction memory over a req/gnt/rvalid handshake.
- Presents the fetched instruction, its PC and PC+4 to decode. `if_id_opcode` (inst[6:2]) drives the control unit directly.
- Handles decode stall, branch/jump redirect, and misaligned redirect targets.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INST, 32'h0000_0013, instruction word driven on bubbles (addi x0,x0,0).

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  word-aligned fetch address.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response data valid.
- imem_rdata  in  32  fetched instruction.
- redirect_valid  in  1  branch taken / JAL / JALR resolved.
- redirect_pc  in  32  target address.
- id_stall  in  1  decode cannot accept a new instruction.
- if_id_valid  out  1  IF/ID holds a real instruction.
- if_id_inst  out  32  instruction word.
- if_id_opcode  out  5  inst[6:2], to control unit.
- if_id_pc  out  32  PC of instruction.
- if_id_pc_plus4  out  32  PC+4, for JAL/JALR link.
- if_id_misaligned  out  1  instruction-address-misaligned fault marker.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC; state=IDLE; imem_req=0; imem_addr=RESET_PC.
  - if_id_valid=0, if_id_inst=NOP_INST, if_id_opcode=5'b00100, if_id_pc=0, if_id_pc_plus4=0, if_id_misaligned=0.
  - Skid buffer and kill flag cleared. Reset mid-transaction abandons any outstanding response; none is consumed after reset.
- FSM: IDLE, REQ, WAIT, HOLD, DRAIN, FAULT.
  - IDLE → REQ on the first clock after reset release.
  - REQ: imem_req=1, imem_addr=pc. On imem_gnt → WAIT. imem_addr changes only in a cycle without gnt.
  - WAIT: imem_req=0, awaiting imem_rvalid.
    - rvalid and IF/ID free (if_id_valid=0 or id_stall=0): load IF/ID (valid=1, inst=rdata, opcode=rdata[6:2], pc, pc+4), pc<=pc+4, → REQ.
    - rvalid and IF/ID blocked: capture rdata in a one-entry skid buffer, → HOLD.
  - HOLD: when id_stall=0, move buffer into IF/ID, pc<=pc+4, → REQ.
  - DRAIN: discard the next imem_rvalid, then → REQ.
  - FAULT: no requests issued. Emit one IF/ID entry (valid=1, inst=NOP_INST, misaligned=1, pc=target), then hold in FAULT until the next redirect.
- Latency: gnt in cycle N, rvalid in cycle N+k (k≥1), if_id_valid=1 from cycle N+k+1. Best-case throughput is one instruction per 2 cycles.
- Stall: while id_stall=1 and if_id_valid=1, all if_id_* outputs hold. Stall has no effect while if_id_valid=0.
- Redirect (highest priority, beats stall and rvalid in the same cycle):
  - pc<=redirect_pc; IF/ID flushed (valid=0, inst=NOP_INST, misaligned=0); skid buffer dropped.
  - Next state:
    - DRAIN, if a request is outstanding (state WAIT without rvalid this cycle, or REQ with gnt this cycle).
    - REQ, if state is WAIT with rvalid this cycle; that response is dropped.
    - REQ, otherwise.
  - If redirect_pc[1:0]≠0: next state FAULT regardless of the above. An outstanding request is still drained before the fault entry is emitted; pc holds the unaligned target.
- Redirect in DRAIN: update pc, remain in DRAIN.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- Never more than one outstanding request. imem_req is never asserted in WAIT, HOLD, DRAIN or FAULT.

Decomposition:
- defines.v gains:
  - `NOP_INST` and `RESET_PC` defaults.
  - Fetch FSM state encodings (3-bit `FETCH_IDLE` … `FETCH_FAULT`).
  - `OPCODE_FIELD` bit-slice constant.
- Sub-module if_id_reg: a 32+32+32+1+1 bit register with load, hold (stall) and flush, where flush has priority. The opcode field is derived from the stored inst.

Test Plan:
- Reset then gnt same cycle, rvalid next cycle, imem_rdata=32'h00500093 → imem_addr=0, then 4, 8. if_id_inst=32'h00500093, if_id_opcode=5'b00100, if_id_pc=0, if_id_pc_plus4=4.
- IF/ID valid, id_stall=1 for 3 cycles while a response arrives → if_id_* unchanged, response held in HOLD. After stall drops, next if_id_pc=+4 and no fetch is lost or duplicated.
- Redirect to 32'h0000_0100 while in WAIT → IF/ID flushed next cycle. The stale rvalid is discarded, next imem_addr=32'h100, and the first valid entry has pc=32'h100.
- Redirect and id_stall together with rvalid in the same cycle → redirect wins: if_id_valid=0, rdata dropped, pc=target.
- redirect_pc=32'h0000_0102 → no imem_req. One entry with if_id_misaligned=1, pc=32'h102, inst=NOP_INST, then idle until a new redirect to 32'h200 resumes fetch.
- pc=32'hFFFF_FFFC fetch completes → next imem_addr=32'h0000_0000. rst_n pulsed low during WAIT → outputs return to reset values immediately and the late rvalid is ignored.
